rptr_fwft_handler: RTL and testbench
====================================

Name: rptr_fwft_handler

Overview:
Read-side pointer handler for the dual-clock FIFO, and the counterpart of the write-side handler.
- Consumes write pointers already synchronised into the read domain.
- Generates the binary and Gray read pointers and the registered memory-empty flag.
- Drives the synchronous FIFO RAM read port (1-cycle read latency).
- Presents words first-word-fall-through through a 2-entry output buffer with a valid/ready handshake, sustaining 1 word/cycle.

Parameters:
PTR_WD, 10, address width; pointers are PTR_WD+1 bits.
DEPTH, 1024, FIFO depth; must equal 2**PTR_WD.
DATA_WD, 8, word width.
AEMPTY_TH, 4, almost_empty_o asserts when data_cnt_r_o <= AEMPTY_TH.

Ports:
r_clk_i  in  1  read-domain clock
r_rst_i  in  1  synchronous active-high reset
b_wptr_sync_i  in  PTR_WD+1  binary write pointer, synchronised to r_clk_i
g_wptr_sync_i  in  PTR_WD+1  Gray write pointer, synchronised to r_clk_i
mem_rdata_i  in  DATA_WD  RAM read data, valid the cycle after mem_ren_o
r_ready_i  in  1  consumer accepts r_data_o
mem_ren_o  out  1  RAM read enable (combinational)
mem_raddr_o  out  PTR_WD  RAM read address = b_rptr_o[PTR_WD-1:0]
b_rptr_o  out  PTR_WD+1  binary read pointer
g_rptr_o  out  PTR_WD+1  Gray read pointer (to write-domain synchroniser)
rempty_o  out  1  no unfetched words left in RAM
r_data_o  out  DATA_WD  head word
r_valid_o  out  1  r_data_o valid
almost_empty_o  out  1  low-occupancy flag
data_cnt_r_o  out  PTR_WD+1  total words held: RAM + in-flight + buffer, range 0..DEPTH

Behaviour:
- Reset (sync, r_rst_i=1 at an edge) clears state:
  - b_rptr_o = g_rptr_o = 0, rempty_o = 1, r_valid_o = 0, r_data_o = 0.
  - Buffer occupancy occ = 0, in-flight bit infl = 0.
  - A RAM return due the cycle after reset is discarded.
- pop = r_valid_o & r_ready_i.
- Issue condition, which is also mem_ren_o: issue = !rempty_o && (occ + infl - pop) < 2. Never issue while rempty_o = 1.
- Pointer update:
  - b_rptr_nxt = b_rptr_o + issue.
  - g_rptr_nxt = b_rptr_nxt ^ (b_rptr_nxt >> 1).
  - Both are registered.
- Empty flag: rempty_o <= (g_rptr_nxt == g_wptr_sync_i). It asserts on the same edge that the pointer passes the last word, so there is no over-read.
- Return path: infl <= issue. When infl = 1, mem_rdata_i is written into the buffer at that edge.
  - Goes to head if occ == 0, or if occ == 1 and pop.
  - Otherwise goes to skid.
- Pop with occ == 2: head <= skid.
- r_valid_o = (occ != 0). Order is strictly preserved.
- r_data_o is stable while r_valid_o & !r_ready_i.
- Latency: a g_wptr_sync_i change from empty causes the following sequence.
  - rempty_o falls at the next edge.
  - Issue happens in that cycle.
  - r_valid_o rises 2 edges later (3 edges total).
- Throughput: with r_ready_i held high and data available, one word per cycle.
- Wrap-around:
  - Pointers wrap modulo 2^(PTR_WD+1).
  - mem_raddr_o wraps modulo DEPTH.
  - Empty is exact equality of all PTR_WD+1 Gray bits.
- Count: data_cnt_r_o = ((b_wptr_sync_i - b_rptr_o) mod 2^(PTR_WD+1)) + infl + occ.
  - Combinational from registered state, full width, so DEPTH is representable.
- almost_empty_o = (data_cnt_r_o <= AEMPTY_TH), combinational.
- Simultaneous return, pop and issue in one cycle: occupancy is net-accounted. occ_nxt = occ + infl - pop, always in 0..2.
- Reset mid-burst: all buffered and in-flight words are dropped. The write side must be reset concurrently.

Decomposition:
- Shared package fifo_pkg holds:
  - bin2gray function.
  - Default PTR_WD / DEPTH / DATA_WD constants.
  - The occupancy type (2-bit).
- One natural sub-module, rd_out_buf: the 2-entry head/skid buffer.
  - Inputs: wr_en, wr_data, pop.
  - Outputs: occ, head data.
  - The top level holds the pointers, empty flag, issue logic and count.

Test Plan:
- Reset, then b/g_wptr_sync_i = 0 -> rempty_o = 1, r_valid_o = 0, mem_ren_o = 0, data_cnt_r_o = 0, almost_empty_o = 1 for 20 cycles.
- Write pointers step 0 -> 1 with RAM[0] = 8'hA5, r_ready_i = 0 -> rempty_o = 0 after 1 edge; r_valid_o = 1 with r_data_o = A5 3 edges after the step; r_data_o held; data_cnt_r_o = 1.
- Pointers jump to 16, r_ready_i = 1 continuously, RAM[i] = i -> r_data_o = 0, 1, 2 … 15 on consecutive cycles, no bubbles; exactly 16 mem_ren_o pulses; rempty_o = 1 at the edge b_rptr_o reaches 16.
- Same traffic, r_ready_i toggling 1,0,0,1 -> no loss or duplication; occ never exceeds 2; mem_ren_o is low whenever occ + infl - pop = 2.
- Start with pointers at 2040 (PTR_WD = 10), write 16 words across the 2047 -> 0 wrap -> mem_raddr_o 1016..1023, 0..7; data in order; rempty_o = 1 at b_rptr_o = 8.
- Pointer at 1024 ahead (full), r_rst_i pulsed mid-stream with a read in flight -> next edge: b_rptr_o = 0, r_valid_o = 0, returned word discarded; data_cnt_r_o reflects the full pointer difference of 1024 with no truncation.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared dual-clock FIFO definitions.
// Pointer defaults, occupancy type and Gray helper.
package fifo_pkg;

  localparam int PTR_WD_D  = 10;
  localparam int DEPTH_D   = 1024;
  localparam int DATA_WD_D = 8;

  typedef logic [1:0] occ_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/rd_out_buf.sv
// Two-entry head/skid output buffer.
// Preserves order, absorbs one in-flight RAM return.
module rd_out_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WD = DATA_WD_D
) (
  input  logic               r_clk_i,
  input  logic               r_rst_i,
  input  logic               wr_en,
  input  logic [DATA_WD-1:0] wr_data,
  input  logic               pop,
  output logic [1:0]         occ,
  output logic [DATA_WD-1:0] head
);

  logic [DATA_WD-1:0] skid;
  logic               to_head;

  assign to_head = wr_en &&
    ((occ == 2'd0) || ((occ == 2'd1) && pop));

  // Net occupancy update; head refills from skid or RAM.
  always_ff @(posedge r_clk_i) begin
    if (r_rst_i) begin
      occ  <= '0;
      head <= '0;
      skid <= '0;
    end else begin
      occ <= occ + {1'b0, wr_en} - {1'b0, pop};
      if (to_head)
        head <= wr_data;
      else if (pop && (occ == 2'd2))
        head <= skid;
      if (wr_en && !to_head)
        skid <= wr_data;
    end
  end

endmodule

// File: rtl/rptr_fwft_handler.sv
// Read-side pointer handler for the dual-clock FIFO.
// Gray/binary read pointers, empty flag, FWFT output.
module rptr_fwft_handler
  import fifo_pkg::*;
#(
  parameter int PTR_WD    = PTR_WD_D,
  parameter int DEPTH     = DEPTH_D,
  parameter int DATA_WD   = DATA_WD_D,
  parameter int AEMPTY_TH = 4
) (
  input  logic              r_clk_i,
  input  logic              r_rst_i,
  input  logic [PTR_WD:0]   b_wptr_sync_i,
  input  logic [PTR_WD:0]   g_wptr_sync_i,
  input  logic [DATA_WD-1:0] mem_rdata_i,
  input  logic              r_ready_i,
  output logic              mem_ren_o,
  output logic [PTR_WD-1:0] mem_raddr_o,
  output logic [PTR_WD:0]   b_rptr_o,
  output logic [PTR_WD:0]   g_rptr_o,
  output logic              rempty_o,
  output logic [DATA_WD-1:0] r_data_o,
  output logic              r_valid_o,
  output logic              almost_empty_o,
  output logic [PTR_WD:0]   data_cnt_r_o
);

  localparam int PW = PTR_WD + 1;
  localparam logic [PTR_WD:0] AE_TH = PW'(AEMPTY_TH);

  if (DEPTH != (1 << PTR_WD)) begin : g_bad_depth
    $error("DEPTH must equal 2**PTR_WD");
  end

  logic [1:0]      occ;
  logic            infl;
  logic            pop;
  logic            issue;
  logic [2:0]      held_nxt;
  logic [PTR_WD:0] b_rptr_nxt;
  logic [PTR_WD:0] g_rptr_nxt;

  assign r_valid_o = (occ != 2'd0);
  assign pop       = r_valid_o & r_ready_i;

  // Words the buffer will hold after this edge, before a new issue.
  assign held_nxt = {1'b0, occ} + {2'b0, infl} - {2'b0, pop};
  assign issue    = !rempty_o && (held_nxt < 3'd2);
  assign mem_ren_o = issue;

  assign b_rptr_nxt  = b_rptr_o + {{PTR_WD{1'b0}}, issue};
  assign g_rptr_nxt  = PW'(bin2gray(32'(b_rptr_nxt)));
  assign mem_raddr_o = b_rptr_o[PTR_WD-1:0];

  // Pointers, empty flag and in-flight marker advance together.
  always_ff @(posedge r_clk_i) begin
    if (r_rst_i) begin
      b_rptr_o <= '0;
      g_rptr_o <= '0;
      rempty_o <= 1'b1;
      infl     <= 1'b0;
    end else begin
      b_rptr_o <= b_rptr_nxt;
      g_rptr_o <= g_rptr_nxt;
      rempty_o <= (g_rptr_nxt == g_wptr_sync_i);
      infl     <= issue;
    end
  end

  assign data_cnt_r_o = (b_wptr_sync_i - b_rptr_o)
    + {{PTR_WD{1'b0}}, infl}
    + {{(PTR_WD-1){1'b0}}, occ};

  assign almost_empty_o = (data_cnt_r_o <= AE_TH);

  rd_out_buf #(
    .DATA_WD(DATA_WD)
  ) u_buf (
    .r_clk_i(r_clk_i),
    .r_rst_i(r_rst_i),
    .wr_en  (infl),
    .wr_data(mem_rdata_i),
    .pop    (pop),
    .occ    (occ),
    .head   (r_data_o)
  );

endmodule

// File: tb/tb_rptr_fwft_handler.sv
// Bench for rptr_fwft_handler.
// Vector table, hand sequences and a random scoreboard run.
module tb_rptr_fwft_handler;

  logic        r_clk_i = 1'b0;
  logic        r_rst_i = 1'b1;
  logic [10:0] wp = '0;
  logic [10:0] b_wptr_sync_i;
  logic [10:0] g_wptr_sync_i;
  logic [7:0]  mem_rdata_i = '0;
  logic        r_ready_i = 1'b0;
  logic        mem_ren_o;
  logic [9:0]  mem_raddr_o;
  logic [10:0] b_rptr_o;
  logic [10:0] g_rptr_o;
  logic        rempty_o;
  logic [7:0]  r_data_o;
  logic        r_valid_o;
  logic        almost_empty_o;
  logic [10:0] data_cnt_r_o;

  logic [7:0]  ram [0:1023];

  int          tests = 0;
  int          fails = 0;
  logic [10:0] fetch = '0;
  logic [10:0] cons = '0;
  bit          mon_en = 1'b0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;

  typedef struct {
    logic [10:0] w;
    logic        rempty;
    logic        valid;
    logic        ae;
  } vec_t;

  vec_t tbl [8];

  assign b_wptr_sync_i = wp;
  assign g_wptr_sync_i = wp ^ (wp >> 1);

  rptr_fwft_handler dut (
    .r_clk_i       (r_clk_i),
    .r_rst_i       (r_rst_i),
    .b_wptr_sync_i (b_wptr_sync_i),
    .g_wptr_sync_i (g_wptr_sync_i),
    .mem_rdata_i   (mem_rdata_i),
    .r_ready_i     (r_ready_i),
    .mem_ren_o     (mem_ren_o),
    .mem_raddr_o   (mem_raddr_o),
    .b_rptr_o      (b_rptr_o),
    .g_rptr_o      (g_rptr_o),
    .rempty_o      (rempty_o),
    .r_data_o      (r_data_o),
    .r_valid_o     (r_valid_o),
    .almost_empty_o(almost_empty_o),
    .data_cnt_r_o  (data_cnt_r_o)
  );

  always #5 r_clk_i = ~r_clk_i;

  // Synchronous RAM model with one-cycle read latency.
  always @(posedge r_clk_i)
    if (mem_ren_o) mem_rdata_i <= ram[mem_raddr_o];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Scoreboard: words fetched vs consumed, order, count.
  task automatic monitor();
    int held;
    int popb;
    logic [10:0] exp_cnt;
    held = int'(11'(fetch - cons));
    popb = (r_valid_o && r_ready_i) ? 1 : 0;
    exp_cnt = 11'(wp - cons);
    chk("held_le2", 32'(held <= 2), 1);
    chk("cnt", 32'(data_cnt_r_o), 32'(exp_cnt));
    chk("aempty", 32'(almost_empty_o), 32'(exp_cnt <= 11'd4));
    chk("gray", 32'(g_rptr_o), 32'(b_rptr_o ^ (b_rptr_o >> 1)));
    chk("raddr_ptr", 32'(mem_raddr_o), 32'(b_rptr_o[9:0]));
    if (prev_stall) begin
      chk("hold_valid", 32'(r_valid_o), 1);
      chk("hold_data", 32'(r_data_o), 32'(prev_data));
    end
    if (popb == 1) begin
      chk("pop_data", 32'(r_data_o), 32'(ram[cons[9:0]]));
      cons = cons + 11'd1;
    end
    if (mem_ren_o) begin
      chk("ren_space", 32'((held - popb) < 2), 1);
      chk("ren_addr", 32'(mem_raddr_o), 32'(fetch[9:0]));
      chk("no_overread", 32'(fetch != wp), 1);
      fetch = fetch + 11'd1;
    end
    prev_stall = r_valid_o && !r_ready_i;
    prev_data  = r_data_o;
  endtask

  task automatic step();
    @(negedge r_clk_i);
    if (mon_en) monitor();
    @(posedge r_clk_i);
    #1;
  endtask

  task automatic do_reset();
    mon_en    = 1'b0;
    r_rst_i   = 1'b1;
    r_ready_i = 1'b0;
    wp        = '0;
    step();
    step();
    r_rst_i    = 1'b0;
    fetch      = '0;
    cons       = '0;
    prev_stall = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);

    tbl[0] = '{11'd0,    1'b1, 1'b0, 1'b1};
    tbl[1] = '{11'd1,    1'b1, 1'b1, 1'b1};
    tbl[2] = '{11'd2,    1'b1, 1'b1, 1'b1};
    tbl[3] = '{11'd3,    1'b0, 1'b1, 1'b1};
    tbl[4] = '{11'd4,    1'b0, 1'b1, 1'b1};
    tbl[5] = '{11'd5,    1'b0, 1'b1, 1'b0};
    tbl[6] = '{11'd16,   1'b0, 1'b1, 1'b0};
    tbl[7] = '{11'd1024, 1'b0, 1'b1, 1'b0};

    // Idle after reset
    do_reset();
    for (int i = 0; i < 20; i++) begin
      chk("idle_rempty", 32'(rempty_o), 1);
      chk("idle_valid", 32'(r_valid_o), 0);
      chk("idle_ren", 32'(mem_ren_o), 0);
      chk("idle_cnt", 32'(data_cnt_r_o), 0);
      chk("idle_ae", 32'(almost_empty_o), 1);
      step();
    end

    // Table: stall with W words written
    for (int v = 0; v < 8; v++) begin
      do_reset();
      wp = tbl[v].w;
      for (int k = 0; k < 6; k++) step();
      chk("tbl_rempty", 32'(rempty_o), 32'(tbl[v].rempty));
      chk("tbl_valid", 32'(r_valid_o), 32'(tbl[v].valid));
      chk("tbl_cnt", 32'(data_cnt_r_o), 32'(tbl[v].w));
      chk("tbl_ae", 32'(almost_empty_o), 32'(tbl[v].ae));
      if (tbl[v].valid)
        chk("tbl_data", 32'(r_data_o), 32'(ram[0]));
    end

    // Single word latency and hold
    do_reset();
    ram[0] = 8'hA5;
    wp = 11'd1;
    step();
    chk("lat_rempty", 32'(rempty_o), 0);
    chk("lat_v1", 32'(r_valid_o), 0);
    step();
    chk("lat_v2", 32'(r_valid_o), 0);
    step();
    chk("lat_v3", 32'(r_valid_o), 1);
    for (int k = 0; k < 5; k++) begin
      chk("lat_data", 32'(r_data_o), 32'hA5);
      chk("lat_cnt", 32'(data_cnt_r_o), 1);
      step();
    end

    // 16-word burst, no bubbles
    do_reset();
    for (int i = 0; i < 16; i++) ram[i] = 8'(i);
    mon_en = 1'b1;
    r_ready_i = 1'b1;
    wp = 11'd16;
    step(); step(); step();
    for (int i = 0; i < 16; i++) begin
      chk("burst_valid", 32'(r_valid_o), 1);
      chk("burst_data", 32'(r_data_o), i);
      step();
    end
    for (int k = 0; k < 4; k++) step();
    chk("burst_fetch", 32'(fetch), 16);
    chk("burst_cons", 32'(cons), 16);
    chk("burst_rempty", 32'(rempty_o), 1);
    chk("burst_rptr", 32'(b_rptr_o), 16);

    // Ready toggling 1,0,0,1
    do_reset();
    mon_en = 1'b1;
    wp = 11'd16;
    for (int k = 0; k < 80; k++) begin
      r_ready_i = (k % 4 == 0) || (k % 4 == 3);
      step();
    end
    chk("tog_cons", 32'(cons), 16);
    chk("tog_fetch", 32'(fetch), 16);

    // Wrap across 2047 -> 0
    do_reset();
    for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
    mon_en = 1'b1;
    r_ready_i = 1'b1;
    wp = 11'd1020;
    for (int k = 0; k < 1030; k++) step();
    wp = 11'd2040;
    for (int k = 0; k < 1030; k++) step();
    chk("wrap_pre", 32'(b_rptr_o), 2040);
    wp = 11'd8;
    for (int k = 0; k < 30; k++) step();
    chk("wrap_cons", 32'(cons), 8);
    chk("wrap_rempty", 32'(rempty_o), 1);
    chk("wrap_rptr", 32'(b_rptr_o), 8);

    // Random traffic
    do_reset();
    mon_en = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      logic [10:0] inc;
      r_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        inc = 11'($urandom_range(1, 4));
        if (11'(wp + inc - cons) <= 11'd1024) wp = wp + inc;
      end
      step();
    end
    r_ready_i = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if (cons == wp && !r_valid_o) break;
      step();
    end
    chk("rnd_drained", 32'(cons == wp), 1);
    chk("rnd_valid", 32'(r_valid_o), 0);
    chk("rnd_rempty", 32'(rempty_o), 1);

    // Reset mid-stream with full FIFO
    do_reset();
    mon_en = 1'b1;
    r_ready_i = 1'b1;
    wp = 11'd1024;
    for (int k = 0; k < 10; k++) step();
    mon_en = 1'b0;
    r_rst_i = 1'b1;
    step();
    chk("mrst_rptr", 32'(b_rptr_o), 0);
    chk("mrst_grptr", 32'(g_rptr_o), 0);
    chk("mrst_valid", 32'(r_valid_o), 0);
    chk("mrst_rempty", 32'(rempty_o), 1);
    chk("mrst_cnt", 32'(data_cnt_r_o), 1024);
    r_rst_i = 1'b0;
    r_ready_i = 1'b0;
    step();
    chk("mrst_discard", 32'(r_valid_o), 0);
    chk("mrst_cnt2", 32'(data_cnt_r_o), 1024);
    step(); step();
    chk("mrst_restart", 32'(r_valid_o), 1);
    chk("mrst_data", 32'(r_data_o), 32'(ram[0]));
    chk("mrst_cnt3", 32'(data_cnt_r_o), 1024);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
